keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one column low per scan tick, builds a
// 16-bit key image per sweep and debounces single-key presses and releases.
module keypad_scan #(
    parameter int unsigned SCAN_CMAX = 50_000,  // 1 ms at 50 MHz
    parameter int unsigned DEB_CNT   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic [3:0] key,
    output logic       key_vld,
    output logic       key_held
);

    localparam int unsigned TW = (SCAN_CMAX > 2) ? $clog2(SCAN_CMAX) : 1;

    typedef enum logic [1:0] {IDLE, DEB, PRESSED, REL} state_t;

    logic [3:0]    row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_n_q, col_n_d;
    logic [15:0]   image_q, image_d;
    logic [3:0]    img_idx;
    logic          sweep_done_q, sweep_done_d;

    logic [4:0]    n_set;
    logic [3:0]    one_idx;
    logic          cls_vld_q, cls_vld_d;
    logic          cls_one_q, cls_one_d;
    logic [3:0]    cls_idx_q, cls_idx_d;
    logic          cls_haskey_q, cls_haskey_d;

    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    cnt_inc;
    logic [3:0]    key_q, key_d;
    logic          key_vld_q, key_vld_d;
    logic          key_held_q, key_held_d;

    // Scan datapath: tick counter, column index, column drive and key image
    always_comb begin
        row_s1_d   = row_n;
        row_s2_d   = row_s1_q;
        tick       = (tick_cnt_q == TW'(SCAN_CMAX - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        col_idx_d  = col_idx_q;
        image_d    = image_q;
        img_idx    = '0;
        if (tick) begin
            col_idx_d = col_idx_q + 2'd1;
            for (int unsigned r = 0; r < 4; r++) begin
                img_idx          = {r[1:0], col_idx_q};
                image_d[img_idx] = ~row_s2_q[r];
            end
        end
        col_n_d      = ~(4'b0001 << col_idx_d);
        sweep_done_d = tick && (col_idx_q == 2'd3);
    end

    // Sweep classification is registered; the FSM consumes it one clk later
    always_comb begin
        n_set   = '0;
        one_idx = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (image_q[k]) begin
                n_set   = n_set + 5'd1;
                one_idx = k[3:0];
            end
        end
        cls_vld_d    = sweep_done_q;
        cls_one_d    = (n_set == 5'd1);
        cls_idx_d    = one_idx;
        cls_haskey_d = image_q[key_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q     <= '1;
            row_s2_q     <= '1;
            tick_cnt_q   <= '0;
            col_idx_q    <= '0;
            col_n_q      <= 4'b1110;
            image_q      <= '0;
            sweep_done_q <= 1'b0;
            cls_vld_q    <= 1'b0;
            cls_one_q    <= 1'b0;
            cls_idx_q    <= '0;
            cls_haskey_q <= 1'b0;
        end else begin
            row_s1_q     <= row_s1_d;
            row_s2_q     <= row_s2_d;
            tick_cnt_q   <= tick_cnt_d;
            col_idx_q    <= col_idx_d;
            col_n_q      <= col_n_d;
            image_q      <= image_d;
            sweep_done_q <= sweep_done_d;
            cls_vld_q    <= cls_vld_d;
            cls_one_q    <= cls_one_d;
            cls_idx_q    <= cls_idx_d;
            cls_haskey_q <= cls_haskey_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cand_q     <= '0;
            cnt_q      <= '0;
            key_q      <= '0;
            key_vld_q  <= 1'b0;
            key_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
            key_vld_q  <= key_vld_d;
            key_held_q <= key_held_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 4'd1;
        if (cls_vld_q) begin
            unique case (state_q)
                IDLE: begin
                    if (cls_one_q) begin
                        cand_d  = cls_idx_q;
                        cnt_d   = 4'd1;
                        state_d = DEB;
                    end
                end
                DEB: begin
                    if (cls_one_q && (cls_idx_q == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == 4'(DEB_CNT)) state_d = PRESSED;
                    end else if (cls_one_q) begin
                        cand_d = cls_idx_q;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (!cls_haskey_q) begin
                        cnt_d   = 4'd1;
                        state_d = REL;
                    end
                end
                REL: begin
                    if (cls_haskey_q) begin
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == 4'(DEB_CNT)) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs, registered on the transition edge
    always_comb begin
        key_d      = key_q;
        key_vld_d  = 1'b0;
        key_held_d = key_held_q;
        if ((state_q == DEB) && (state_d == PRESSED)) begin
            key_d      = cand_q;
            key_vld_d  = 1'b1;
            key_held_d = 1'b1;
        end
        if ((state_q == REL) && (state_d == IDLE)) key_held_d = 1'b0;
    end

    assign col_n    = col_n_q;
    assign key      = key_q;
    assign key_vld  = key_vld_q;
    assign key_held = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a keypad matrix model drives row_n from
// col_n, and every key_vld pulse is matched against a queue of expected keys.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key;
    logic        key_vld;
    logic        key_held;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pushed = 0;
    int pulses = 0;
    int vld_cyc = 0;
    int t0     = 0;
    logic [3:0] exp_q[$];

    keypad_scan #(.SCAN_CMAX(4), .DEB_CNT(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .col_n    (col_n),
        .row_n    (row_n),
        .key      (key),
        .key_vld  (key_vld),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key shorts its row to its column
    always_comb begin
        int idx;
        row_n = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                idx = r * 4 + c;
                if (pressed[idx[3:0]] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check("col_n_onehot", 16'($countones(~col_n)), 16'd1);
        if (key_vld === 1'b1) begin
            pulses++;
            vld_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_key_vld", 16'(key_vld), 16'd0);
            else check("key_at_vld", 16'(key), 16'(exp_q.pop_front()));
        end
    endtask

    task automatic push_key(input logic [3:0] k);
        exp_q.push_back(k);
        pushed++;
    endtask

    task automatic wait_sweep_start();
        logic [3:0] prev;
        bit found;
        prev  = col_n;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (prev == 4'b0111 && col_n == 4'b1110) found = 1'b1;
            prev = col_n;
        end
        check("sweep_start_seen", 16'(found), 16'd1);
    endtask

    task automatic wait_vld(input int bound);
        int start;
        start = pulses;
        for (int i = 0; i < bound && pulses == start; i++) step();
        check("key_vld_seen", 16'(pulses - start), 16'd1);
    endtask

    task automatic wait_held(input logic v, input int bound);
        for (int i = 0; i < bound && key_held !== v; i++) step();
        check("key_held_reached", 16'(key_held), 16'(v));
    endtask

    initial begin
        logic [3:0] ec;
        rst_n   = 1'b0;
        pressed = '0;
        repeat (3) step();
        check("rst_col_n", 16'(col_n), 16'hE);
        check("rst_key", 16'(key), 16'd0);
        check("rst_key_vld", 16'(key_vld), 16'd0);
        check("rst_key_held", 16'(key_held), 16'd0);
        rst_n = 1'b1;

        // idle scan: 4 clks per column, outputs quiet
        for (int i = 1; i <= 32; i++) begin
            step();
            ec = ~(4'b0001 << ((i / 4) % 4));
            check("idle_col_n", 16'(col_n), 16'(ec));
            check("idle_key", 16'(key), 16'd0);
            check("idle_key_vld", 16'(key_vld), 16'd0);
            check("idle_key_held", 16'(key_held), 16'd0);
        end

        // key 9 held stable, then released
        wait_sweep_start();
        pressed = 16'h0200;
        push_key(4'd9);
        t0 = cyc;
        wait_vld(80);
        check("lat_key9", 16'(vld_cyc - t0), 16'd50);
        repeat (40) step();
        check("held_key9", 16'(key_held), 16'd1);
        check("key9_while_held", 16'(key), 16'd9);
        wait_sweep_start();
        pressed = '0;
        t0 = cyc;
        wait_held(1'b0, 80);
        check("rel_lat_key9", 16'(cyc - t0), 16'd50);
        check("key9_kept", 16'(key), 16'd9);

        // key 5 bounce: one sweep present, one absent, then stable
        wait_sweep_start();
        pressed = 16'h0020;
        wait_sweep_start();
        pressed = '0;
        wait_sweep_start();
        pressed = 16'h0020;
        push_key(4'd5);
        t0 = cyc;
        wait_vld(80);
        check("lat_key5_bounce", 16'(vld_cyc - t0), 16'd50);
        wait_sweep_start();
        pressed = '0;
        wait_held(1'b0, 80);

        // keys 3 and 12 together, then 12 released
        wait_sweep_start();
        pressed = 16'h1008;
        repeat (56) step();
        check("multi_no_held", 16'(key_held), 16'd0);
        wait_sweep_start();
        pressed = 16'h0008;
        push_key(4'd3);
        t0 = cyc;
        wait_vld(80);
        check("lat_key3", 16'(vld_cyc - t0), 16'd50);
        wait_sweep_start();
        pressed = '0;
        wait_held(1'b0, 80);

        // key 7 held, key 0 added, then 7 released
        wait_sweep_start();
        pressed = 16'h0080;
        push_key(4'd7);
        wait_vld(80);
        wait_sweep_start();
        pressed = 16'h0081;
        repeat (40) step();
        check("multi_held_key7", 16'(key_held), 16'd1);
        check("multi_key7", 16'(key), 16'd7);
        wait_sweep_start();
        pressed = 16'h0001;
        push_key(4'd0);
        t0 = cyc;
        wait_held(1'b0, 80);
        check("rel_lat_key7", 16'(cyc - t0), 16'd50);
        check("key7_kept", 16'(key), 16'd7);
        wait_vld(80);
        check("lat_key0_after_rel", 16'(vld_cyc - t0), 16'd98);
        wait_sweep_start();
        pressed = '0;
        wait_held(1'b0, 80);

        // reset pulse while key 9 is pressed
        wait_sweep_start();
        pressed = 16'h0200;
        push_key(4'd9);
        wait_vld(80);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_key_held", 16'(key_held), 16'd0);
        check("midrst_key", 16'(key), 16'd0);
        check("midrst_key_vld", 16'(key_vld), 16'd0);
        check("midrst_col_n", 16'(col_n), 16'hE);
        step();
        rst_n = 1'b1;
        push_key(4'd9);
        t0 = cyc;
        wait_vld(80);
        check("lat_key9_reacq", 16'(vld_cyc - t0), 16'd50);
        step();
        check("held_key9_reacq", 16'(key_held), 16'd1);
        wait_sweep_start();
        pressed = '0;
        wait_held(1'b0, 80);

        check("exp_queue_empty", 16'(exp_q.size()), 16'd0);
        check("pulse_count", 16'(pulses), 16'(pushed));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
